// File: rtl/pipe_arith_unit.sv
// pipe_arith_unit: three-stage valid/ready pipeline computing ((a+b)+(c-d))*d or (a+b)*(c-d),
// with flush and overflow flag. Define PIPE_ARITH_SAT_EN to saturate F instead of wrapping.
module pipe_arith_unit #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             ovf
);
  localparam int SW = WIDTH + 2;
  localparam int XW = WIDTH + 3;
  localparam int PW = 2 * WIDTH + 4;

  function automatic logic f_ovf(input logic signed [PW-1:0] p);
    return p[PW-1] | (|p[PW-2:WIDTH]);
  endfunction

  function automatic logic [WIDTH-1:0] f_result(input logic signed [PW-1:0] p);
`ifdef PIPE_ARITH_SAT_EN
    if (p[PW-1])
      return '0;
    else if (|p[PW-2:WIDTH])
      return '1;
    else
      return p[WIDTH-1:0];
`else
    return p[WIDTH-1:0];
`endif
  endfunction

  logic                 r_vld_p0;
  logic                 r_mode_p0;
  logic signed [SW-1:0] r_s1_p0;
  logic signed [SW-1:0] r_s2_p0;
  logic [WIDTH-1:0]     r_d_p0;
  logic                 r_vld_p1;
  logic signed [XW-1:0] r_x_p1;
  logic signed [XW-1:0] r_y_p1;
  logic                 r_vld_p2;
  logic signed [PW-1:0] r_p_p2;

  logic                 w_adv;
  logic signed [SW-1:0] w_s1;
  logic signed [SW-1:0] w_s2;
  logic signed [XW-1:0] w_x;
  logic signed [XW-1:0] w_y;
  logic signed [PW-1:0] w_p;

  // Whole pipe advances together; a stalled output freezes every stage.
  assign w_adv = ~r_vld_p2 | out_ready;

  assign w_s1 = $signed({2'b00, a}) + $signed({2'b00, b});
  assign w_s2 = $signed({2'b00, c}) - $signed({2'b00, d});

  assign w_x = r_mode_p0 ? XW'(r_s1_p0) : XW'(r_s1_p0) + XW'(r_s2_p0);
  assign w_y = r_mode_p0 ? XW'(r_s2_p0) : $signed({3'b000, r_d_p0});

  assign w_p = PW'(r_x_p1) * PW'(r_y_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_mode_p0 <= 1'b0;
      r_s1_p0   <= '0;
      r_s2_p0   <= '0;
      r_d_p0    <= '0;
      r_vld_p1  <= 1'b0;
      r_x_p1    <= '0;
      r_y_p1    <= '0;
      r_vld_p2  <= 1'b0;
      r_p_p2    <= '0;
    end else begin
      if (w_adv) begin
        // Stage 1: operand pre-add/subtract
        r_vld_p0  <= in_valid;
        r_mode_p0 <= mode;
        r_s1_p0   <= w_s1;
        r_s2_p0   <= w_s2;
        r_d_p0    <= d;
        // Stage 2: multiplier operand select
        r_vld_p1  <= r_vld_p0;
        r_x_p1    <= w_x;
        r_y_p1    <= w_y;
        // Stage 3: exact product
        r_vld_p2  <= r_vld_p1;
        r_p_p2    <= w_p;
      end
      if (flush) begin
        r_vld_p0 <= 1'b0;
        r_vld_p1 <= 1'b0;
        r_vld_p2 <= 1'b0;
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld_p2;
  assign F         = f_result(r_p_p2);
  assign ovf       = f_ovf(r_p_p2);

endmodule

// File: tb/tb_pipe_arith_unit.sv
// Table-driven plus scoreboard bench for pipe_arith_unit (WIDTH=10); honours PIPE_ARITH_SAT_EN.
module tb_pipe_arith_unit;
  localparam int W = 10;
  localparam longint MAXV = (longint'(1) << W) - 1;
  localparam int NV = 14;

  typedef struct {
    logic m;
    int   a, b, c, d;
    int   fw, fs;
    logic o;
  } vec_t;

  typedef struct {
    logic [W-1:0] f;
    logic         o;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst, flush, in_valid, in_ready, mode, out_valid, out_ready, ovf;
  logic [W-1:0] a, b, c, d, F;

  vec_t         tbl [NV];
  exp_t         sb [$];
  int           n_pass, n_total, n_out, n0;
  int           cyc = 0;
  bit           chk_lat, rnd_done, hold_prev;
  logic [W-1:0] hF, exp_f_in, ef;
  logic         hO, exp_o_in;

  pipe_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .F(F), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, req);
  endtask

  function automatic void model(input logic m, input logic [W-1:0] ia, ib, ic, id,
                                output logic [W-1:0] f, output logic o);
    longint s, t, p;
    s = longint'(ia) + longint'(ib);
    t = longint'(ic) - longint'(id);
    p = m ? s * t : (s + t) * longint'(id);
    o = (p < 0) || (p > MAXV);
`ifdef PIPE_ARITH_SAT_EN
    if (p < 0) f = '0;
    else if (p > MAXV) f = '1;
    else f = p[W-1:0];
`else
    f = p[W-1:0];
`endif
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_F", int'(F), int'(hF));
          chk("stall_ovf", int'(ovf), int'(hO));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) chk("unexpected_out", int'(F), -1);
          else begin
            e = sb.pop_front();
            chk("F", int'(F), int'(e.f));
            chk("ovf", int'(ovf), int'(e.o));
            if (chk_lat) chk("latency", cyc - e.cyc, 3);
          end
        end
        hold_prev = out_valid && !out_ready && !flush;
        hF = F;
        hO = ovf;
        if (flush) sb.delete();
        else if (in_valid && in_ready) begin
          e.f = exp_f_in;
          e.o = exp_o_in;
          e.cyc = cyc;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic send(input logic m, input logic [W-1:0] ia, ib, ic, id,
                      input logic [W-1:0] f, input logic o);
    int n = 0;
    mode = m; a = ia; b = ib; c = ic; d = id;
    exp_f_in = f; exp_o_in = o;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic m, o;
    logic [W-1:0] ra, rb, rc, rd, f;
    m  = 1'($urandom_range(0, 1));
    ra = W'($urandom_range(0, 1023));
    rb = W'($urandom_range(0, 1023));
    rc = W'($urandom_range(0, 1023));
    rd = W'($urandom_range(0, 1023));
    model(m, ra, rb, rc, rd, f, o);
    send(m, ra, rb, rc, rd, f, o);
  endtask

  task automatic send_tbl(input int i);
`ifdef PIPE_ARITH_SAT_EN
    ef = W'(tbl[i].fs);
`else
    ef = W'(tbl[i].fw);
`endif
    send(tbl[i].m, W'(tbl[i].a), W'(tbl[i].b), W'(tbl[i].c), W'(tbl[i].d), ef, tbl[i].o);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic bp_stall();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_first_valid", int'(out_valid), 1);
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_F"}, int'(F), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mode = 1'b0;
    a = '0; b = '0; c = '0; d = '0; out_ready = 1'b1;
    n_pass = 0; n_total = 0; n_out = 0; chk_lat = 1'b0; rnd_done = 1'b0; hold_prev = 1'b0;
    exp_f_in = '0; exp_o_in = 1'b0; hF = '0; hO = 1'b0; ef = '0;

    //             mode  a     b     c     d    F wrap F sat ovf
    tbl[0]  = '{1'b0,   10,   12,    6,    3,   75,   75, 1'b0};
    tbl[1]  = '{1'b0,   10,   10,    5,    3,   66,   66, 1'b0};
    tbl[2]  = '{1'b0,   20,   11,    1,    4,  112,  112, 1'b0};
    tbl[3]  = '{1'b0,    8,   15,    5,    0,    0,    0, 1'b0};
    tbl[4]  = '{1'b0,   30,    1,    2,    4,  116,  116, 1'b0};
    tbl[5]  = '{1'b1,   10,   12,    6,    3,   66,   66, 1'b0};
    tbl[6]  = '{1'b1,    1,    1,    0,    5, 1014,    0, 1'b1};
    tbl[7]  = '{1'b0, 1000, 1000,    0,    3,  871, 1023, 1'b1};
    tbl[8]  = '{1'b1, 1023, 1023, 1023,    0,    2, 1023, 1'b1};
    tbl[9]  = '{1'b0,  300,   41,    3,    3, 1023, 1023, 1'b0};
    tbl[10] = '{1'b1,  512,    0,    2,    0,    0, 1023, 1'b1};
    tbl[11] = '{1'b0,    0,    0,    0,    5,  999,    0, 1'b1};
    tbl[12] = '{1'b0, 1023, 1023, 1023, 1023,    2, 1023, 1'b1};
    tbl[13] = '{1'b1,    0,    0,    0,    7,    0,    0, 1'b0};

    fork
      monitor();
    join_none

    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back mixed-mode stream, fixed latency expected
    chk_lat = 1'b1;
    for (int i = 0; i < NV; i++) send_tbl(i);
    drain();

    // backpressure: 6 in, 4-cycle stall at the first result
    chk_lat = 1'b0;
    n0 = n_out;
    fork
      for (int i = 0; i < 6; i++) send_rand();
      bp_stall();
    join
    drain();
    chk("bp_count", n_out - n0, 6);

    // flush while in flight with a new input presented
    chk_lat = 1'b1;
    send_rand();
    send_rand();
    mode = 1'b0; a = 10'd5; b = 10'd5; c = 10'd5; d = 10'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flushA_in_ready", int'(in_ready), 1);
    chk("flushA_valid0", int'(out_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("flushA_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    n0 = n_out;
    send_tbl(0);
    @(negedge clk); chk("alone_c1", int'(out_valid), 0);
    @(negedge clk); chk("alone_c2", int'(out_valid), 0);
    @(negedge clk); chk("alone_c3", int'(out_valid), 1);
    @(negedge clk); chk("alone_c4", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("alone_count", n_out - n0, 1);

    // flush during a stall with three results held
    chk_lat = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flushB_valid", int'(out_valid), 0);
    chk("flushB_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flushB_quiet", int'(out_valid), 0);
    end
    @(posedge clk); #1;

    // reset mid-stream with an input presented
    send_tbl(7);
    send_tbl(12);
    in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_idle("rst_stream");
    @(posedge clk); #1;

    // reset during a stall
    out_ready = 1'b0;
    send_tbl(7);
    send_tbl(8);
    send_tbl(12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_stall");
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", int'(out_valid), 0);
    end
    @(posedge clk); #1;

    // random stream with bubbles and random consumer stalls
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_rand();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rand_count", n_out - n0, 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
